dmem_arbiter: RTL and testbench



---
 rtl/dmem_arbiter.sv | 109 ++++++++++
 tb/tb_dmem_arbiter.sv | 184 ++++++++++++++++++
 2 files changed

// File: rtl/dmem_arbiter.sv
// Data-memory arbiter between the CPU MEM stage and a debug/loader port.
// Optional stall statistics counter enabled by defining DMEM_ARB_STATS_EN.
module dmem_arbiter #(
  parameter int ADDR_W     = 5,
  parameter int STARVE_MAX = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cpu_req_i,
  input  logic              cpu_we_i,
  input  logic [ADDR_W-1:0] cpu_addr_i,
  input  logic [31:0]       cpu_wdata_i,
  output logic [31:0]       cpu_rdata_o,
  output logic              cpu_stall_o,
  input  logic              dbg_req_i,
  input  logic              dbg_we_i,
  input  logic [ADDR_W-1:0] dbg_addr_i,
  input  logic [31:0]       dbg_wdata_i,
  output logic              dbg_ack_o,
  output logic              dbg_err_o,
  output logic [31:0]       dbg_rdata_o,
  output logic              mem_en_o,
  output logic              mem_we_o,
  output logic [ADDR_W-1:0] mem_addr_o,
  output logic [31:0]       mem_wdata_o,
  input  logic [31:0]       mem_rdata_i,
  output logic [15:0]       stall_cnt_o
);

  localparam int CNT_W = $clog2(STARVE_MAX + 1);
  localparam logic [CNT_W-1:0] WAIT_MAX = CNT_W'(STARVE_MAX);

  localparam logic [0:0] ST_ARB = 1'b0;
  localparam logic [0:0] ST_ACK = 1'b1;

  logic [0:0]       r_state;
  logic [CNT_W-1:0] r_wait_cnt;
  logic             r_ack;
  logic             r_err;
  logic [31:0]      r_rdata;

  logic w_dbg_pend;
  logic w_dbg_mis;
  logic w_dbg_gnt;
  logic w_cpu_gnt;

  // Reset (rst low) masks every grant so the memory sees no strobe.
  always_comb begin
    w_dbg_pend = rst && dbg_req_i && (r_state == ST_ARB);
    w_dbg_mis  = w_dbg_pend && (dbg_addr_i[1:0] != 2'b00);
    w_dbg_gnt  = w_dbg_pend && !w_dbg_mis &&
                 (!cpu_req_i || (r_wait_cnt == WAIT_MAX));
    w_cpu_gnt  = rst && cpu_req_i && !w_dbg_gnt;
  end

  always_comb begin
    mem_en_o    = w_dbg_gnt || w_cpu_gnt;
    mem_we_o    = w_dbg_gnt ? dbg_we_i : (w_cpu_gnt && cpu_we_i);
    mem_addr_o  = w_dbg_gnt ? dbg_addr_i : cpu_addr_i;
    mem_wdata_o = w_dbg_gnt ? dbg_wdata_i : cpu_wdata_i;
  end

  assign cpu_rdata_o = mem_rdata_i;
  assign cpu_stall_o = cpu_req_i && w_dbg_gnt;
  assign dbg_ack_o   = r_ack;
  assign dbg_err_o   = r_err;
  assign dbg_rdata_o = r_rdata;

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state    <= ST_ARB;
      r_wait_cnt <= '0;
      r_ack      <= 1'b0;
      r_err      <= 1'b0;
      r_rdata    <= '0;
    end else begin
      r_state <= (r_state == ST_ARB && (w_dbg_gnt || w_dbg_mis)) ? ST_ACK : ST_ARB;

      // Starvation count only advances while an eligible request is losing.
      if (!dbg_req_i || w_dbg_gnt || w_dbg_mis)
        r_wait_cnt <= '0;
      else if (w_dbg_pend && r_wait_cnt != WAIT_MAX)
        r_wait_cnt <= r_wait_cnt + 1'b1;

      r_ack <= w_dbg_gnt || w_dbg_mis;
      r_err <= w_dbg_mis;
      if (w_dbg_mis)
        r_rdata <= '0;
      else if (w_dbg_gnt)
        r_rdata <= dbg_we_i ? 32'h0 : mem_rdata_i;
    end
  end

`ifdef DMEM_ARB_STATS_EN
  logic [15:0] r_stall_cnt;

  always_ff @(posedge clk) begin
    if (!rst)
      r_stall_cnt <= '0;
    else if (cpu_stall_o && r_stall_cnt != 16'hFFFF)
      r_stall_cnt <= r_stall_cnt + 16'd1;
  end

  assign stall_cnt_o = r_stall_cnt;
`else
  assign stall_cnt_o = 16'h0000;
`endif

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed bench for dmem_arbiter with a small behavioural data memory.
module tb_dmem_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        cpu_req_i, cpu_we_i;
  logic [4:0]  cpu_addr_i;
  logic [31:0] cpu_wdata_i, cpu_rdata_o;
  logic        cpu_stall_o;
  logic        dbg_req_i, dbg_we_i;
  logic [4:0]  dbg_addr_i;
  logic [31:0] dbg_wdata_i;
  logic        dbg_ack_o, dbg_err_o;
  logic [31:0] dbg_rdata_o;
  logic        mem_en_o, mem_we_o;
  logic [4:0]  mem_addr_o;
  logic [31:0] mem_wdata_o, mem_rdata_i;
  logic [15:0] stall_cnt_o;

  logic [31:0] mem [0:7];
  int n_cmp = 0;
  int n_err = 0;
  logic [15:0] exp_stats;

  always #5 clk = ~clk;

  assign mem_rdata_i = mem[mem_addr_o[4:2]];
  always @(posedge clk)
    if (mem_en_o && mem_we_o) mem[mem_addr_o[4:2]] <= mem_wdata_o;

  dmem_arbiter #(.ADDR_W(5), .STARVE_MAX(4)) dut (
    .clk(clk), .rst(rst),
    .cpu_req_i(cpu_req_i), .cpu_we_i(cpu_we_i), .cpu_addr_i(cpu_addr_i),
    .cpu_wdata_i(cpu_wdata_i), .cpu_rdata_o(cpu_rdata_o), .cpu_stall_o(cpu_stall_o),
    .dbg_req_i(dbg_req_i), .dbg_we_i(dbg_we_i), .dbg_addr_i(dbg_addr_i),
    .dbg_wdata_i(dbg_wdata_i), .dbg_ack_o(dbg_ack_o), .dbg_err_o(dbg_err_o),
    .dbg_rdata_o(dbg_rdata_o),
    .mem_en_o(mem_en_o), .mem_we_o(mem_we_o), .mem_addr_o(mem_addr_o),
    .mem_wdata_o(mem_wdata_o), .mem_rdata_i(mem_rdata_i),
    .stall_cnt_o(stall_cnt_o)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    for (int i = 0; i < 8; i++) mem[i] = 32'h0;
    mem[0] = 32'd5;
    mem[2] = 32'h22;
    rst = 1'b0;
    cpu_req_i = 1'b1; cpu_we_i = 1'b0; cpu_addr_i = 5'd0; cpu_wdata_i = 32'h0;
    dbg_req_i = 1'b1; dbg_we_i = 1'b0; dbg_addr_i = 5'd0; dbg_wdata_i = 32'h0;

    // Reset with both requests high
    for (int k = 0; k < 2; k++) begin
      step();
      check("rst_mem_en", mem_en_o, 0);
      check("rst_stall", cpu_stall_o, 0);
      check("rst_ack", dbg_ack_o, 0);
    end
    rst = 1'b1; cpu_req_i = 1'b0; dbg_req_i = 1'b0;
    #1;
    check("idle_mem_en", mem_en_o, 0);
    check("idle_err", dbg_err_o, 0);
    check("idle_rdata", dbg_rdata_o, 0);
    check("idle_stall_cnt", stall_cnt_o, 0);

    // Idle debug write then read
    dbg_req_i = 1'b1; dbg_we_i = 1'b1; dbg_addr_i = 5'h04; dbg_wdata_i = 32'hDEADBEEF;
    #1;
    check("wr_mem_we", mem_we_o, 1);
    check("wr_mem_addr", mem_addr_o, 32'h04);
    step();
    check("wr_ack", dbg_ack_o, 1);
    check("wr_err", dbg_err_o, 0);
    dbg_req_i = 1'b0;
    step();
    check("wr_ack_drop", dbg_ack_o, 0);
    dbg_req_i = 1'b1; dbg_we_i = 1'b0;
    #1;
    check("rd_mem_en", mem_en_o, 1);
    check("rd_mem_we", mem_we_o, 0);
    step();
    check("rd_ack", dbg_ack_o, 1);
    check("rd_rdata", dbg_rdata_o, 32'hDEADBEEF);

    // Request still held during ACK: no second access
    check("held_mem_en", mem_en_o, 0);
    step();
    check("held_ack_once", dbg_ack_o, 0);
    dbg_req_i = 1'b0;
    step();

    // Starvation under continuous CPU loads of 0x08
    cpu_req_i = 1'b1; cpu_we_i = 1'b0; cpu_addr_i = 5'h08;
    dbg_req_i = 1'b1; dbg_we_i = 1'b0; dbg_addr_i = 5'h00;
    for (int k = 0; k < 4; k++) begin
      #1;
      check("starve_cpu_stall", cpu_stall_o, 0);
      check("starve_cpu_addr", mem_addr_o, 32'h08);
      check("starve_cpu_rdata", cpu_rdata_o, 32'h22);
      step();
    end
    #1;
    check("forced_stall", cpu_stall_o, 1);
    check("forced_addr", mem_addr_o, 32'h00);
    step();
    check("forced_ack", dbg_ack_o, 1);
    check("forced_rdata", dbg_rdata_o, 32'd5);
    check("ack_cycle_stall", cpu_stall_o, 0);
    check("ack_cycle_cpu_addr", mem_addr_o, 32'h08);
    dbg_req_i = 1'b0;
    step();
    check("forced_ack_drop", dbg_ack_o, 0);

    // Misaligned debug with CPU load of 0x00
    cpu_addr_i = 5'h00; dbg_addr_i = 5'h06;
    dbg_req_i = 1'b1;
    #1;
    check("mis_stall", cpu_stall_o, 0);
    check("mis_cpu_addr", mem_addr_o, 32'h00);
    check("mis_cpu_rdata", cpu_rdata_o, 32'd5);
    step();
    check("mis_ack", dbg_ack_o, 1);
    check("mis_err", dbg_err_o, 1);
    check("mis_rdata", dbg_rdata_o, 0);
    dbg_req_i = 1'b0;
    step();
    check("mis_ack_drop", dbg_ack_o, 0);
    check("mis_err_drop", dbg_err_o, 0);

    // Three forced debug writes under CPU load, counters cleared first
    rst = 1'b0;
    step();
    rst = 1'b1;
    check("clr_stall_cnt", stall_cnt_o, 0);
    cpu_addr_i = 5'h08;
    for (int g = 0; g < 3; g++) begin
      dbg_req_i = 1'b1; dbg_we_i = 1'b1; dbg_addr_i = 5'h0C; dbg_wdata_i = 32'h100 + g;
      repeat (4) step();
      check("stat_stall", cpu_stall_o, 1);
      step();
      check("stat_ack", dbg_ack_o, 1);
      dbg_req_i = 1'b0;
      step();
    end
    check("stat_mem_wr", mem[3], 32'h102);
`ifdef DMEM_ARB_STATS_EN
    exp_stats = 16'd3;
`else
    exp_stats = 16'd0;
`endif
    check("stat_cnt", stall_cnt_o, exp_stats);

    // Reset asserted during ACK
    dbg_req_i = 1'b1; dbg_we_i = 1'b0; dbg_addr_i = 5'h00;
    repeat (5) step();
    check("pre_rst_ack", dbg_ack_o, 1);
    rst = 1'b0;
    #1;
    check("rst_ack_mem_en", mem_en_o, 0);
    check("rst_ack_stall", cpu_stall_o, 0);
    step();
    check("rst_ack_supp", dbg_ack_o, 0);
    check("rst_stall_cnt", stall_cnt_o, 0);
    rst = 1'b1; dbg_req_i = 1'b0; cpu_req_i = 1'b0;
    step();
    check("post_rst_ack", dbg_ack_o, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
